vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster coordinate stream (x, y, active) and the VGA sync signals consumed by every overlay pixel generator and the final RGB mux.
- Acts as the source end of the coordinate/active interface that the overlay generators sample, and drives hsync/vsync to the pins.
- Default timing is 640x480 at 60 Hz with a 25.175 MHz pixel rate.
- All outputs are registered, so x, y, active, hsync and vsync are mutually skew-free.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 1, clk cycles per pixel tick; legal values 1..4

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  run enable; when low, all timing is frozen
- x  output  10  current horizontal count, range 0..H_TOTAL-1
- y  output  10  current vertical count, range 0..V_TOTAL-1
- active  output  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  horizontal sync at HSYNC_POL
- vsync  output  1  vertical sync at VSYNC_POL
- line_start  output  1  one-clk pulse in the first cycle in which x==0
- frame_start  output  1  one-clk pulse in the first cycle in which x==0 and y==0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = the vertical equivalent (525).
  - Elaboration fails if either total exceeds 1024, or if CLK_DIV is outside 1..4.
- Reset values: x=0, y=0, active=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, divider count=0.
  - No start pulse is generated on reset release.
- Pixel tick:
  - CLK_DIV=1: tick = en.
  - Otherwise a 2-bit divider counts 0..CLK_DIV-1 while en is high; tick fires when the divider is at CLK_DIV-1, then the divider wraps to 0.
- On each tick:
  - x increments; at x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 together with x wrap, y wraps to 0.
- Output alignment: active, hsync and vsync are registered from the next-state counter values in the same edge that loads x and y. Latency from counter to sync is 0 cycles relative to x and y.
- hsync is asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. With defaults this is x = 656..751.
- vsync is asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the entire line. With defaults this is y = 490..491.
- Strobes:
  - line_start and frame_start are high exactly one clk cycle after the edge that loads x=0 (resp. x=0 and y=0).
  - They stay one cycle wide for any CLK_DIV.
- en low:
  - Counters, divider and all level outputs hold their values.
  - Strobes are forced to 0.
  - When en returns high, counting resumes from the held state with no skipped or duplicated pixel.
- Reset mid-frame: all outputs return to their reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNTER_EN.
- Defined:
  - Adds output port frame_count [7:0], reset value 0.
  - Increments on the same edge that asserts frame_start; wraps 255 -> 0.
  - Used by the animation overlays.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480 default timing constants;
  - COORD_W=10;
  - localparams for H_TOTAL/V_TOTAL and the sync start/end positions.
  - The overlay blocks use the same constants for screen-relative placement.
- One sub-module, pixel_tick_div: the divider that produces tick from en and CLK_DIV. It is a pass-through when CLK_DIV=1.
- Counters and output registers stay in the top module.

Test Plan:
1. Reset release, defaults, en=1:
   - First cycle shows x=0, y=0, active=1, hsync=1, vsync=1.
   - After 640 clks, x=640 and active=0.
2. Horizontal timing:
   - hsync is low for exactly 96 clks (x 656..751).
   - x=799 -> next cycle x=0 and y=1; line_start is high for 1 clk.
3. Vertical timing:
   - vsync is low for exactly 1600 clks (y 490..491).
   - frame_start pulses once every 420000 clks, coincident with x=0, y=0.
4. CLK_DIV=2: x advances every 2 clks; hsync is low for 192 clks; line_start is 1 clk wide.
5. en pause and async reset:
   - en low for 10 clks at x=100 -> x holds at 100 and the strobes stay 0; resumes at x=101.
   - rst asserted between edges at x=300, y=200 -> reset values appear before the next edge.
6. With VGA_TIMING_FRAME_COUNTER_EN: after 3 frames frame_count=3; after 256 frames frame_count=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 VGA pipeline and its overlays.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HSYNC_END   = HSYNC_START + DEF_H_SYNC;
  localparam int unsigned VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VSYNC_END   = VSYNC_START + DEF_V_SYNC;

  // Half-open window test done at 32 bits so an end bound of MAX_TOTAL does not truncate.
  function automatic logic in_window(input logic [COORD_W-1:0] c,
                                     input int unsigned lo, input int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: one tick every CLK_DIV enabled clocks; with CLK_DIV=1 tick equals en.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam logic [1:0] LAST = 2'(CLK_DIV - 1);

  logic [1:0] cnt;

  // With CLK_DIV=1 LAST is 0, cnt never leaves 0 and tick_c degenerates to en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? 2'd0 : cnt + 2'd1;
    end
  end

  assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster/sync generator with skew-free registered x, y, active, hsync, vsync and strobes.
// Optional frame_count output when VGA_TIMING_FRAME_COUNTER_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  ,
  output logic [7:0]         frame_count
`endif
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);

  if (H_TOT > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOT > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..4");
  end

  logic tick_c;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick_c (tick_c)
  );

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               active_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               line_nxt;
  logic               frame_nxt;

  // Next raster position; level outputs derive from it so they load alongside x and y.
  always_comb begin
    x_nxt = x + COORD_W'(1);
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : y + COORD_W'(1);
    end
    active_nxt = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
    hsync_nxt  = in_window(x_nxt, HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt  = in_window(y_nxt, VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
    line_nxt   = (x_nxt == '0);
    frame_nxt  = line_nxt && (y_nxt == '0);
  end

  // Strobes only rise on a tick edge, so they stay one clk wide for any CLK_DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick_c) begin
        x           <= x_nxt;
        y           <= y_nxt;
        active      <= active_nxt;
        hsync       <= hsync_nxt;
        vsync       <= vsync_nxt;
        line_start  <= line_nxt;
        frame_start <= frame_nxt;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 8'd0;
    end else if (tick_c && frame_nxt) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing, CLK_DIV=2 and a tiny positive-polarity raster share clk/rst/en.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  logic [9:0] x0, y0, x1, y1, xs, ys;
  logic a0, hs0, vs0, ls0, fs0;
  logic a1, hs1, vs1, ls1, fs1;
  logic as_, hss, vss, lss, fss;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [7:0] fc0, fc1, fcs;
`endif

  int errors = 0;
  int checks = 0;
  int ne     = 0;

  vga_timing_gen u_d0 (
    .clk(clk), .rst(rst), .en(en), .x(x0), .y(y0), .active(a0), .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , .frame_count(fc0)
`endif
  );

  vga_timing_gen #(.CLK_DIV(2)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .x(x1), .y(y1), .active(a1), .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , .frame_count(fc1)
`endif
  );

  // 15 x 8 raster: hsync x=10..12, vsync y=5..6, both active-high.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1)
  ) u_ds (
    .clk(clk), .rst(rst), .en(en), .x(xs), .y(ys), .active(as_), .hsync(hss), .vsync(vss),
    .line_start(lss), .frame_start(fss)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , .frame_count(fcs)
`endif
  );

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      if (en) ne++;
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL rst_x got=%0d exp=0", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL rst_y got=%0d exp=0", y0); end
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL rst_active got=%b exp=1", a0); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL rst_vsync got=%b exp=1", vs0); end
    checks++; if (ls0 !== 1'b0 || fs0 !== 1'b0) begin errors++; $display("FAIL rst_strobes got=%b%b exp=00", ls0, fs0); end
    checks++; if (hss !== 1'b0 || vss !== 1'b0) begin errors++; $display("FAIL rst_pos_pol got=%b%b exp=00", hss, vss); end
    rst = 1'b0;
    ne  = 0;
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL release_x got=%0d exp=0", x0); end
    step(1);
    checks++; if (x0 !== 10'd1) begin errors++; $display("FAIL first_tick_x got=%0d exp=1", x0); end
    checks++; if (ls0 !== 1'b0 || fs0 !== 1'b0 || lss !== 1'b0 || fss !== 1'b0)
      begin errors++; $display("FAIL release_no_pulse got=%b%b%b%b exp=0000", ls0, fs0, lss, fss); end
  endtask

  task automatic test_hactive;
    step(639 - ne);
    checks++; if (x0 !== 10'd639 || a0 !== 1'b1) begin errors++; $display("FAIL x639_active got x=%0d a=%b exp x=639 a=1", x0, a0); end
    step(1);
    checks++; if (x0 !== 10'd640 || a0 !== 1'b0) begin errors++; $display("FAIL x640_active got x=%0d a=%b exp x=640 a=0", x0, a0); end
  endtask

  task automatic test_hsync_line;
    int lo = 0, first = -1, last = -1, ls_n = 0, ls_x = -1, y_wrap = -1, x_wrap = -1;
    int prev;
    for (int i = 0; i < 800; i++) begin
      prev = int'(x0);
      step(1);
      if (hs0 === 1'b0) begin
        lo++;
        if (first < 0) first = int'(x0);
        last = int'(x0);
      end
      if (ls0 === 1'b1) begin ls_n++; ls_x = int'(x0); end
      if (prev == 799) begin y_wrap = int'(y0); x_wrap = int'(x0); end
    end
    checks++; if (lo != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", lo); end
    checks++; if (first != 656 || last != 751) begin errors++; $display("FAIL hsync_window got=%0d..%0d exp=656..751", first, last); end
    checks++; if (x_wrap != 0 || y_wrap != 1) begin errors++; $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=1", x_wrap, y_wrap); end
    checks++; if (ls_n != 1 || ls_x != 0) begin errors++; $display("FAIL line_start got n=%0d x=%0d exp n=1 x=0", ls_n, ls_x); end
  endtask

  task automatic test_clkdiv;
    int lo = 0, ls_n = 0, ls_x = -1;
    checks++; if (int'(x1) != (ne / 2) % 800) begin errors++; $display("FAIL div2_x got=%0d exp=%0d", x1, (ne / 2) % 800); end
    for (int i = 0; i < 1600; i++) begin
      step(1);
      if (hs1 === 1'b0) lo++;
      if (ls1 === 1'b1) begin ls_n++; ls_x = int'(x1); end
    end
    checks++; if (lo != 192) begin errors++; $display("FAIL div2_hsync_width got=%0d exp=192", lo); end
    checks++; if (ls_n != 1 || ls_x != 0) begin errors++; $display("FAIL div2_line_start got n=%0d x=%0d exp n=1 x=0", ls_n, ls_x); end
    checks++; if (int'(x1) != (ne / 2) % 800) begin errors++; $display("FAIL div2_x_after got=%0d exp=%0d", x1, (ne / 2) % 800); end
  endtask

  task automatic test_vertical;
    int vs_n = 0, hs_n = 0, act_n = 0, fs_n = 0, fs_bad = 0;
    for (int i = 0; i < 240; i++) begin
      step(1);
      if (vss === 1'b1) vs_n++;
      if (hss === 1'b1) hs_n++;
      if (as_ === 1'b1) act_n++;
      if (fss === 1'b1) begin
        fs_n++;
        if (xs !== 10'd0 || ys !== 10'd0) fs_bad++;
      end
    end
    checks++; if (vs_n != 60) begin errors++; $display("FAIL small_vsync_width got=%0d exp=60", vs_n); end
    checks++; if (hs_n != 48) begin errors++; $display("FAIL small_hsync_total got=%0d exp=48", hs_n); end
    checks++; if (act_n != 64) begin errors++; $display("FAIL small_active_total got=%0d exp=64", act_n); end
    checks++; if (fs_n != 2 || fs_bad != 0) begin errors++; $display("FAIL small_frame_start got n=%0d bad=%0d exp n=2 bad=0", fs_n, fs_bad); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL default_vsync_idle got=%b exp=1", vs0); end
  endtask

  task automatic test_pause;
    int strb = 0;
    logic [9:0] xs_h, x1_h;
    step((100 - int'(x0) + 800) % 800);
    checks++; if (x0 !== 10'd100) begin errors++; $display("FAIL pause_setup got=%0d exp=100", x0); end
    xs_h = xs;
    x1_h = x1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      strb += int'(ls0) + int'(fs0) + int'(ls1) + int'(fs1) + int'(lss) + int'(fss);
    end
    checks++; if (x0 !== 10'd100) begin errors++; $display("FAIL pause_hold_x got=%0d exp=100", x0); end
    checks++; if (xs !== xs_h || x1 !== x1_h) begin errors++; $display("FAIL pause_hold_other got=%0d,%0d exp=%0d,%0d", xs, x1, xs_h, x1_h); end
    checks++; if (strb != 0) begin errors++; $display("FAIL pause_strobes got=%0d exp=0", strb); end
    en = 1'b1;
    step(1);
    checks++; if (x0 !== 10'd101) begin errors++; $display("FAIL pause_resume got=%0d exp=101", x0); end
    checks++; if (int'(x1) != (ne / 2) % 800) begin errors++; $display("FAIL pause_div2_resume got=%0d exp=%0d", x1, (ne / 2) % 800); end
  endtask

  task automatic test_async_reset;
    step((300 - int'(x0) + 800) % 800);
    checks++; if (x0 !== 10'd300 || y0 === 10'd0) begin errors++; $display("FAIL areset_setup got x=%0d y=%0d exp x=300 y>0", x0, y0); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (x0 !== 10'd0 || y0 !== 10'd0) begin errors++; $display("FAIL areset_xy got=%0d,%0d exp=0,0", x0, y0); end
    checks++; if (a0 !== 1'b1 || hs0 !== 1'b1 || vs0 !== 1'b1) begin errors++; $display("FAIL areset_levels got=%b%b%b exp=111", a0, hs0, vs0); end
    checks++; if (x1 !== 10'd0 || xs !== 10'd0 || hss !== 1'b0) begin errors++; $display("FAIL areset_others got=%0d,%0d,%b exp=0,0,0", x1, xs, hss); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ne  = 0;
  endtask

  task automatic test_back_to_back;
    step(1);
    checks++; if (x0 !== 10'd1 || fs0 !== 1'b0) begin errors++; $display("FAIL restart got x=%0d fs=%b exp x=1 fs=0", x0, fs0); end
    step(14);
    checks++; if (xs !== 10'd0 || ys !== 10'd1 || lss !== 1'b1 || fss !== 1'b0)
      begin errors++; $display("FAIL small_wrap got x=%0d y=%0d ls=%b fs=%b exp 0 1 1 0", xs, ys, lss, fss); end
    step(1);
    checks++; if (lss !== 1'b0) begin errors++; $display("FAIL small_line_width got=%b exp=0", lss); end
  endtask

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  task automatic test_frame_count;
    step(360 - ne);
    checks++; if (fcs !== 8'd3) begin errors++; $display("FAIL frame_count_3 got=%0d exp=3", fcs); end
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL frame_count_default got=%0d exp=0", fc0); end
    step(30719 - ne);
    checks++; if (fcs !== 8'd255) begin errors++; $display("FAIL frame_count_255 got=%0d exp=255", fcs); end
    step(1);
    checks++; if (fcs !== 8'd0) begin errors++; $display("FAIL frame_count_wrap got=%0d exp=0", fcs); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_hactive();
    test_hsync_line();
    test_clkdiv();
    test_vertical();
    test_pause();
    test_async_reset();
    test_back_to_back();
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    test_frame_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
